// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pkg
// Brief    : Opcodes, instruction field positions, delay units and FSM states
//            shared by the valve sequencer and its delay timer.
// Revision : 1.0 - initial release
// ============================================================================
package seq_pkg;

    localparam logic [2:0] OP_HALT  = 3'b000;
    localparam logic [2:0] OP_SET   = 3'b001;
    localparam logic [2:0] OP_DELAY = 3'b010;
    localparam logic [2:0] OP_JUMP  = 3'b011;

    localparam int OP_MSB    = 20;
    localparam int OP_LSB    = 18;
    localparam int VALVE_MSB = 17;
    localparam int VALVE_LSB = 14;
    localparam int VALUE_BIT = 0;
    localparam int COUNT_MSB = 8;
    localparam int COUNT_LSB = 4;
    localparam int UNIT_MSB  = 3;
    localparam int UNIT_LSB  = 1;
    localparam int TGT_MSB   = 17;
    localparam int TGT_LSB   = 10;

    localparam logic [2:0] UNIT_US = 3'b000;
    localparam logic [2:0] UNIT_MS = 3'b001;
    localparam logic [2:0] UNIT_S  = 3'b010;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        DELAY = 3'd3,
        HALT  = 3'd4
    } seq_state_t;

    function automatic logic unit_valid(input logic [2:0] unit);
        return (unit == UNIT_US) || (unit == UNIT_MS) || (unit == UNIT_S);
    endfunction

    function automatic logic [31:0] unit_cycles(input logic [2:0] unit, input int cycles_per_us);
        case (unit)
            UNIT_MS: return 32'(cycles_per_us) * 32'd1000;
            UNIT_S:  return 32'(cycles_per_us) * 32'd1000000;
            default: return 32'(cycles_per_us);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_delay_timer.sv
`default_nettype none
// ============================================================================
// Module   : seq_delay_timer
// Brief    : Prescaler plus 5-bit unit counter; done is high on the last of
//            count*unit_cycles active cycles.
// Revision : 1.0 - initial release
// ============================================================================
module seq_delay_timer
    import seq_pkg::*;
#(
    parameter int CYCLES_PER_US = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       load,
    input  logic [4:0] count,
    input  logic [2:0] unit,
    output logic       done
);

    logic [31:0] r_presc;
    logic [31:0] r_reload;
    logic [4:0]  r_count;
    logic        r_active;
    logic [31:0] w_reload;

    assign w_reload = unit_cycles(unit, CYCLES_PER_US) - 32'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc  <= '0;
            r_reload <= '0;
            r_count  <= '0;
            r_active <= 1'b0;
        end else if (clear) begin
            r_active <= 1'b0;
        end else if (load) begin
            r_active <= (count != 5'd0);
            r_reload <= w_reload;
            r_presc  <= w_reload;
            r_count  <= count - 5'd1;
        end else if (r_active) begin
            if (r_presc == 32'd0) begin
                if (r_count == 5'd0) begin
                    r_active <= 1'b0;
                end else begin
                    r_count <= r_count - 5'd1;
                    r_presc <= r_reload;
                end
            end else begin
                r_presc <= r_presc - 32'd1;
            end
        end
    end

    assign done = r_active && (r_presc == 32'd0) && (r_count == 5'd0);

endmodule
`default_nettype wire

// File: rtl/valve_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : valve_sequencer
// Brief    : Fetches 21-bit valve instructions and drives 16 registered valves.
//            Define SEQ_LOOP_EN to enable the JUMP opcode (011).
// Revision : 1.0 - initial release
// ============================================================================
module valve_sequencer
    import seq_pkg::*;
#(
    parameter logic [7:0] START_ADDR    = 8'd1,
    parameter int         CYCLES_PER_US = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    output logic [7:0]  pc,
    input  logic [20:0] instr,
    output logic [15:0] valve_state,
    output logic        busy,
    output logic        halted,
    output logic        err
);

    seq_state_t  r_state, w_state_nxt;
    logic [7:0]  r_pc, w_pc_nxt;
    logic [20:0] r_ir, w_ir_nxt;
    logic [15:0] r_valves, w_valves_nxt;
    logic        r_err, w_err_nxt;
    logic        w_tmr_load, w_tmr_clear, w_tmr_done, w_advance;

    logic [2:0]  w_op;
    logic [3:0]  w_valve;
    logic [4:0]  w_count;
    logic [2:0]  w_unit;
    logic        w_unused_ir;

    assign w_op        = r_ir[OP_MSB:OP_LSB];
    assign w_valve     = r_ir[VALVE_MSB:VALVE_LSB];
    assign w_count     = r_ir[COUNT_MSB:COUNT_LSB];
    assign w_unit      = r_ir[UNIT_MSB:UNIT_LSB];
    assign w_unused_ir = ^r_ir[13:9];

`ifdef SEQ_LOOP_EN
    logic [7:0] w_tgt;
    assign w_tgt = r_ir[TGT_MSB:TGT_LSB];
`endif

    seq_delay_timer #(
        .CYCLES_PER_US (CYCLES_PER_US)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (w_tmr_clear),
        .load  (w_tmr_load),
        .count (w_count),
        .unit  (w_unit),
        .done  (w_tmr_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_pc     <= 8'd0;
            r_ir     <= '0;
            r_valves <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_ir     <= w_ir_nxt;
            r_valves <= w_valves_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_ir_nxt     = r_ir;
        w_valves_nxt = r_valves;
        w_err_nxt    = r_err;
        w_tmr_load   = 1'b0;
        w_tmr_clear  = 1'b0;
        w_advance    = 1'b0;

        // stop overrides every transition and suppresses any EXEC side effect
        if (stop) begin
            w_state_nxt = IDLE;
            w_tmr_clear = 1'b1;
        end else begin
            case (r_state)
                IDLE, HALT: begin
                    if (start) begin
                        w_state_nxt = FETCH;
                        w_pc_nxt    = START_ADDR;
                        w_err_nxt   = 1'b0;
                    end
                end
                FETCH: begin
                    w_ir_nxt    = instr;
                    w_state_nxt = EXEC;
                end
                EXEC: begin
                    case (w_op)
                        OP_SET: begin
                            w_valves_nxt[w_valve] = r_ir[VALUE_BIT];
                            w_advance             = 1'b1;
                        end
                        OP_DELAY: begin
                            if (!unit_valid(w_unit)) begin
                                w_err_nxt   = 1'b1;
                                w_state_nxt = HALT;
                            end else if (w_count == 5'd0) begin
                                w_advance = 1'b1;
                            end else begin
                                w_tmr_load  = 1'b1;
                                w_state_nxt = DELAY;
                            end
                        end
                        OP_HALT: w_state_nxt = HALT;
`ifdef SEQ_LOOP_EN
                        OP_JUMP: begin
                            w_pc_nxt    = w_tgt;
                            w_state_nxt = FETCH;
                        end
`endif
                        default: begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = HALT;
                        end
                    endcase
                end
                DELAY: begin
                    if (w_tmr_done) begin
                        w_advance = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end

        // the program counter never wraps; running off the end is an error
        if (w_advance) begin
            if (r_pc == 8'hFF) begin
                w_err_nxt   = 1'b1;
                w_state_nxt = HALT;
            end else begin
                w_pc_nxt    = r_pc + 8'd1;
                w_state_nxt = FETCH;
            end
        end
    end

    assign pc          = r_pc;
    assign valve_state = r_valves;
    assign err         = r_err;
    assign busy        = (r_state == FETCH) || (r_state == EXEC) || (r_state == DELAY);
    assign halted      = (r_state == HALT);

endmodule
`default_nettype wire

// File: tb/tb_valve_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_valve_sequencer
// Brief    : Scoreboard bench for valve_sequencer with CYCLES_PER_US = 2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_valve_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [7:0]  pc;
    logic [20:0] instr;
    logic [15:0] valve_state;
    logic        busy, halted, err;

    logic [20:0] mem [256];
    assign instr = mem[pc];

    valve_sequencer #(
        .START_ADDR    (8'd1),
        .CYCLES_PER_US (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .pc          (pc),
        .instr       (instr),
        .valve_state (valve_state),
        .busy        (busy),
        .halted      (halted),
        .err         (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        int          at;
        logic [26:0] exp;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total = 0;
    int   t0 = 0;
    logic [15:0] vb;

    // expected snapshot: {valve_state, pc, busy, halted, err}
    always @(negedge clk) begin
        logic [26:0] act;
        exp_t e;
        act = {valve_state, pc, busy, halted, err};
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            total++;
            if (e.at != cyc) begin
                $display("FAIL %s: sample for cycle %0d missed (now %0d)", e.name, e.at, cyc);
            end else if (act !== e.exp) begin
                $display("FAIL %s @%0d: got vs=%h pc=%h busy=%b halted=%b err=%b, want vs=%h pc=%h busy=%b halted=%b err=%b",
                         e.name, cyc, act[26:11], act[10:3], act[2], act[1], act[0],
                         e.exp[26:11], e.exp[10:3], e.exp[2], e.exp[1], e.exp[0]);
            end else begin
                passed++;
            end
        end
    end

    function automatic logic [20:0] i_set(input logic [3:0] v, input logic val);
        return {3'b001, v, 13'd0, val};
    endfunction

    function automatic logic [20:0] i_delay(input logic [4:0] count, input logic [2:0] unit);
        return {3'b010, 4'd0, 5'd0, count, unit, 1'b0};
    endfunction

    function automatic logic [20:0] i_op(input logic [2:0] op);
        return {op, 18'd0};
    endfunction

    function automatic logic [20:0] i_jump(input logic [7:0] tgt);
        return {3'b011, tgt, 10'd0};
    endfunction

    task automatic chk(input string name, input int off, input logic [15:0] vs, input logic [7:0] p,
                       input logic b, input logic h, input logic e);
        exp_t x;
        x.name = name;
        x.at   = t0 + off;
        x.exp  = {vs, p, b, h, e};
        sb.push_back(x);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 21'd0;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t0 = cyc;
    endtask

    task automatic drain(input string name, input int limit);
        int n = 0;
        while (sb.size() > 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (sb.size() > 0) begin
            total++;
            $display("FAIL %s: %0d checks never reached, got pending=%0d want 0", name, sb.size(), sb.size());
            sb.delete();
        end
    endtask

    initial begin
        clear_mem();
        t0 = 0;
        chk("reset_state", 2, 16'h0000, 8'd0, 0, 0, 0);
        wait_cyc(3);
        reset = 1'b0;
        drain("reset", 10);

        // SET v1=1; DELAY 2 ms; SET v1=0; HALT -> v1 high 4004 cycles
        clear_mem();
        mem[1] = i_set(4'd1, 1'b1);
        mem[2] = i_delay(5'd2, 3'b001);
        mem[3] = i_set(4'd1, 1'b0);
        pulse_start();
        chk("p1_fetch",     0,    16'h0000, 8'd1, 1, 0, 0);
        chk("p1_v1_on",     2,    16'h0002, 8'd2, 1, 0, 0);
        chk("p1_in_delay",  4003, 16'h0002, 8'd2, 1, 0, 0);
        chk("p1_last_high", 4005, 16'h0002, 8'd3, 1, 0, 0);
        chk("p1_v1_off",    4006, 16'h0000, 8'd4, 1, 0, 0);
        chk("p1_pre_halt",  4007, 16'h0000, 8'd4, 1, 0, 0);
        chk("p1_halt",      4008, 16'h0000, 8'd4, 0, 1, 0);
        drain("p1", 4100);

        // SET v15, SET v0, HALT with a start pulse while busy
        clear_mem();
        mem[1] = i_set(4'd15, 1'b1);
        mem[2] = i_set(4'd0, 1'b1);
        pulse_start();
        chk("p2_v15",        2, 16'h8000, 8'd2, 1, 0, 0);
        chk("p2_v0",         4, 16'h8001, 8'd3, 1, 0, 0);
        chk("p2_halt",       6, 16'h8001, 8'd3, 0, 1, 0);
        wait_cyc(t0 + 1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        drain("p2", 50);

        // DELAY count 0 then DELAY 3 us
        clear_mem();
        mem[1] = i_delay(5'd0, 3'b000);
        mem[2] = i_delay(5'd3, 3'b000);
        pulse_start();
        chk("p3_zero_pass",  2,  16'h8001, 8'd2, 1, 0, 0);
        chk("p3_delay_end",  9,  16'h8001, 8'd2, 1, 0, 0);
        chk("p3_after_dly",  10, 16'h8001, 8'd3, 1, 0, 0);
        chk("p3_halt",       12, 16'h8001, 8'd3, 0, 1, 0);
        drain("p3", 50);

        // illegal opcode 111
        clear_mem();
        mem[1] = i_op(3'b111);
        pulse_start();
        chk("p4_exec",       1, 16'h8001, 8'd1, 1, 0, 0);
        chk("p4_illegal",    2, 16'h8001, 8'd1, 0, 1, 1);
        drain("p4", 50);

        // restart clears err
        mem[1] = i_op(3'b000);
        pulse_start();
        chk("p5_err_clear",  0, 16'h8001, 8'd1, 1, 0, 0);
        chk("p5_halt",       2, 16'h8001, 8'd1, 0, 1, 0);
        drain("p5", 50);

        // bad delay unit
        mem[1] = i_delay(5'd1, 3'b011);
        pulse_start();
        chk("p6_bad_unit",   2, 16'h8001, 8'd1, 0, 1, 1);
        drain("p6", 50);

        vb = 16'h8001;
`ifdef SEQ_LOOP_EN
        clear_mem();
        mem[1] = i_set(4'd2, 1'b1);
        mem[2] = i_set(4'd2, 1'b0);
        mem[3] = i_jump(8'd1);
        pulse_start();
        chk("p7_v2_on",      2,  16'h8005, 8'd2, 1, 0, 0);
        chk("p7_v2_off",     4,  16'h8001, 8'd3, 1, 0, 0);
        chk("p7_jumped",     6,  16'h8001, 8'd1, 1, 0, 0);
        chk("p7_v2_on2",     8,  16'h8005, 8'd2, 1, 0, 0);
        chk("p7_stopped",    9,  16'h8005, 8'd2, 0, 0, 0);
        chk("p7_held",       11, 16'h8005, 8'd2, 0, 0, 0);
        wait_cyc(t0 + 8);
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        drain("p7", 50);
        vb = 16'h8005;
`else
        clear_mem();
        mem[1] = i_jump(8'd1);
        pulse_start();
        chk("p7_jump_illegal", 2, 16'h8001, 8'd1, 0, 1, 1);
        drain("p7", 50);
`endif

        // stop during a 1 s delay
        clear_mem();
        mem[1] = i_set(4'd5, 1'b1);
        mem[2] = i_delay(5'd1, 3'b010);
        pulse_start();
        chk("p8_v5_on",      2, vb | 16'h0020, 8'd2, 1, 0, 0);
        chk("p8_stopped",    6, vb | 16'h0020, 8'd2, 0, 0, 0);
        chk("p8_held",       8, vb | 16'h0020, 8'd2, 0, 0, 0);
        wait_cyc(t0 + 5);
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        drain("p8", 50);
        vb = vb | 16'h0020;

        // run off the end of memory
        for (int i = 1; i < 256; i++) mem[i] = i_set(4'd14, 1'b1);
        pulse_start();
        chk("p9_v14",        2,   vb | 16'h4000, 8'd2,  1, 0, 0);
        chk("p9_at_ff",      508, vb | 16'h4000, 8'hFF, 1, 0, 0);
        chk("p9_overflow",   510, vb | 16'h4000, 8'hFF, 0, 1, 1);
        drain("p9", 600);
        vb = vb | 16'h4000;

        // asynchronous reset in the middle of a delay
        clear_mem();
        mem[1] = i_set(4'd3, 1'b1);
        mem[2] = i_delay(5'd5, 3'b001);
        pulse_start();
        chk("p10_start",     0, vb, 8'd1, 1, 0, 0);
        chk("p10_in_delay",  9, vb | 16'h0008, 8'd2, 1, 0, 0);
        wait_cyc(t0 + 9);
        @(posedge clk);
        #2 reset = 1'b1;
        chk("p10_async_rst", 10, 16'h0000, 8'd0, 0, 0, 0);
        drain("p10", 50);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
